// File: rtl/gray_run_sched.sv
// gray_run_sched: one 3-bit Gray-code run-detector core shared by NCH serial bit channels.
// Macro GRAY_RUN_RR_EN selects round-robin arbitration; without it, fixed lowest-index priority.
module gray_run_sched #(
   parameter int NCH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [NCH-1:0]   req,
   input  logic [NCH-1:0]   in,
   output logic [NCH-1:0]   gnt,
   output logic [NCH-1:0]   op,
   output logic [3*NCH-1:0] state
);

   logic [3*NCH-1:0] r_state;
   logic [NCH-1:0]   r_op;
   logic [NCH-1:0]   w_gnt;

   // Successor in the Gray run order; S7 (100) wraps to S0.
   function automatic logic [2:0] f_gray_next(input logic [2:0] s);
      logic [2:0] n;
      case (s)
         3'b000:  n = 3'b001;
         3'b001:  n = 3'b011;
         3'b011:  n = 3'b010;
         3'b010:  n = 3'b110;
         3'b110:  n = 3'b111;
         3'b111:  n = 3'b101;
         3'b101:  n = 3'b100;
         3'b100:  n = 3'b000;
         default: n = 3'b000;
      endcase
      return n;
   endfunction

`ifdef GRAY_RUN_RR_EN
   logic [2:0] r_ptr;

   function automatic logic [NCH-1:0] f_rr_pick(input logic [NCH-1:0] r, input logic [2:0] p);
      logic [NCH-1:0] g;
      logic           found;
      int             idx;
      g     = {NCH{1'b0}};
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         idx = (int'(p) + i) % NCH;
         if (!found && r[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic logic [2:0] f_ptr_after(input logic [NCH-1:0] g, input logic [2:0] p);
      logic [2:0] n;
      n = p;
      for (int k = 0; k < NCH; k++) begin
         if (g[k]) begin
            n = 3'((k + 1) % NCH);
         end
      end
      return n;
   endfunction

   // Grant search starts at the pointer; clr suppresses every grant.
   always_comb begin
      if (clr) begin
         w_gnt = {NCH{1'b0}};
      end else begin
         w_gnt = f_rr_pick(req, r_ptr);
      end
   end

   // Pointer moves past the accepted channel; no grant (including clr) holds it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 3'd0;
      end else begin
         r_ptr <= f_ptr_after(w_gnt, r_ptr);
      end
   end
`else
   function automatic logic [NCH-1:0] f_fp_pick(input logic [NCH-1:0] r);
      logic [NCH-1:0] g;
      logic           found;
      g     = {NCH{1'b0}};
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && r[i]) begin
            g[i]  = 1'b1;
            found = 1'b1;
         end
      end
      return g;
   endfunction

   // Lowest requesting index wins; clr suppresses every grant.
   always_comb begin
      if (clr) begin
         w_gnt = {NCH{1'b0}};
      end else begin
         w_gnt = f_fp_pick(req);
      end
   end
`endif

   // Shared core: only the granted channel advances; op pulses on the S7 -> S0 wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= {(3*NCH){1'b0}};
         r_op    <= {NCH{1'b0}};
      end else if (clr) begin
         r_state <= {(3*NCH){1'b0}};
         r_op    <= {NCH{1'b0}};
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (w_gnt[k]) begin
               r_state[3*k +: 3] <= in[k] ? f_gray_next(r_state[3*k +: 3]) : 3'b000;
               r_op[k]           <= in[k] & (r_state[3*k +: 3] == 3'b100);
            end else begin
               r_op[k] <= 1'b0;
            end
         end
      end
   end

   assign gnt   = w_gnt;
   assign op    = r_op;
   assign state = r_state;

endmodule

// File: tb/tb_gray_run_sched.sv
// Self-checking bench for gray_run_sched: directed scenarios plus random traffic against a run-length model.
// Honours GRAY_RUN_RR_EN the same way as the design.
module tb_gray_run_sched;
   localparam int NCH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic [NCH-1:0]   req;
   logic [NCH-1:0]   in_bits;
   logic [NCH-1:0]   gnt;
   logic [NCH-1:0]   op;
   logic [3*NCH-1:0] state;

   gray_run_sched #(.NCH(NCH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .req   (req),
      .in    (in_bits),
      .gnt   (gnt),
      .op    (op),
      .state (state)
   );

   always #5 clk = ~clk;

   int             checks = 0;
   int             failures = 0;
   int             run_len[NCH];
   int             ptr;
   logic [NCH-1:0] exp_op;
   logic [NCH-1:0] last_g;
   logic [2:0]     gray_tab[8];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [NCH-1:0] model_gnt();
      logic [NCH-1:0] g;
      int             c;
      g = '0;
      if (!clr) begin
`ifdef GRAY_RUN_RR_EN
         for (int i = 0; i < NCH; i++) begin
            c = (ptr + i) % NCH;
            if (req[c]) begin
               g[c] = 1'b1;
               break;
            end
         end
`else
         for (int i = 0; i < NCH; i++) begin
            if (req[i]) begin
               g[i] = 1'b1;
               break;
            end
         end
`endif
      end
      return g;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) run_len[k] = 0;
      ptr    = 0;
      exp_op = '0;
   endtask

   task automatic check_outputs();
      for (int k = 0; k < NCH; k++) begin
         check_eq($sformatf("state%0d", k), 32'(state[3*k +: 3]), 32'(gray_tab[run_len[k]]));
      end
      check_eq("op", 32'(op), 32'(exp_op));
   endtask

   // Inputs already driven (after a negedge): check gnt, clock once, update model, check registers.
   task automatic step();
      logic [NCH-1:0] g;
      #1;
      g = model_gnt();
      check_eq("gnt", 32'(gnt), 32'(g));
      @(posedge clk);
      exp_op = '0;
      if (clr) begin
         for (int k = 0; k < NCH; k++) run_len[k] = 0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (g[k]) begin
               if (!in_bits[k]) run_len[k] = 0;
               else if (run_len[k] == 7) begin
                  run_len[k] = 0;
                  exp_op[k]  = 1'b1;
               end else run_len[k]++;
               ptr = (k + 1) % NCH;
            end
         end
      end
      last_g = g;
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic [NCH-1:0] r, input logic [NCH-1:0] d, input logic c);
      @(negedge clk);
      req     = r;
      in_bits = d;
      clr     = c;
      step();
   endtask

   logic [NCH-1:0] keep;
   logic [NCH-1:0] nr;
   logic [NCH-1:0] nd;

   initial begin
      gray_tab[0] = 3'b000; gray_tab[1] = 3'b001; gray_tab[2] = 3'b011; gray_tab[3] = 3'b010;
      gray_tab[4] = 3'b110; gray_tab[5] = 3'b111; gray_tab[6] = 3'b101; gray_tab[7] = 3'b100;
      rst_n = 1'b0; clr = 1'b0; req = '0; in_bits = '0; last_g = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      check_eq("gnt_reset", 32'(gnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single channel run of eight 1s, then idle.
      repeat (8) drive(4'b0001, 4'b0001, 1'b0);
      check_eq("op0_after8", 32'(op[0]), 32'd1);
      drive(4'b0000, 4'b0000, 1'b0);

      // Break on channel 1, then seven more 1s.
      drive(4'b0010, 4'b0010, 1'b0);
      drive(4'b0010, 4'b0010, 1'b0);
      drive(4'b0010, 4'b0010, 1'b0);
      drive(4'b0010, 4'b0010, 1'b0);
      drive(4'b0010, 4'b0000, 1'b0);
      drive(4'b0010, 4'b0010, 1'b0);
      check_eq("brk_state1", 32'(state[5:3]), 32'd1);
      repeat (7) drive(4'b0010, 4'b0010, 1'b0);
      check_eq("brk_op1", 32'(op[1]), 32'd1);

      // All channels requesting with 1s held.
      drive(4'b0000, 4'b0000, 1'b1);
      repeat (40) drive(4'b1111, 4'b1111, 1'b0);

      // clr while channel 2 sits at S5 with a pending request.
      drive(4'b0000, 4'b0000, 1'b1);
      repeat (5) drive(4'b0100, 4'b0100, 1'b0);
      check_eq("ch2_s5", 32'(state[8:6]), 32'b111);
      drive(4'b0100, 4'b0100, 1'b1);
      check_eq("clr_state", 32'(state), 32'd0);

      // Random traffic; ungranted requests are held stable.
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         keep = clr ? req : (req & ~last_g);
         nr   = keep | NCH'($urandom);
         for (int k = 0; k < NCH; k++) nd[k] = ($urandom_range(0, 7) != 0);
         req     = nr;
         in_bits = (in_bits & keep) | (nd & ~keep);
         clr     = ($urandom_range(0, 31) == 0);
         step();
      end

      // Async reset with channel 3 at S7 and a 1 pending.
      drive(4'b0000, 4'b0000, 1'b1);
      repeat (7) drive(4'b1000, 4'b1000, 1'b0);
      check_eq("ch3_s7", 32'(state[11:9]), 32'b100);
      @(negedge clk);
      req = 4'b1000; in_bits = 4'b1000; clr = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("arst_state", 32'(state), 32'd0);
      check_eq("arst_op", 32'(op), 32'd0);
      @(posedge clk);
      #1;
      check_eq("arst_op3", 32'(op[3]), 32'd0);
      check_eq("arst_state_hold", 32'(state), 32'd0);
      @(negedge clk);
      req = '0; in_bits = '0;
      rst_n = 1'b1;
      last_g = '0;
      repeat (4) drive(4'b1001, 4'b1001, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
